// File: rtl/mult_seq_param.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement via sign/magnitude.
// Latency k+2 clocks from accepted start (k = highest set bit index of |multiplier| plus 1).
module mult_seq_param #(
    parameter int DW        = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic [DW-1:0]     i_multiplicand,
    input  logic [DW-1:0]     i_multiplier,
    output logic [2*DW-1:0]   o_product,
    output logic              o_ready,
    output logic              o_done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2*DW-1:0]     r_mcand;
    logic [DW-1:0]       r_mplier;
    logic [2*DW-1:0]     r_acc;
    logic                r_sign;
    logic [2*DW-1:0]     r_product;
    logic                r_done;

    logic                w_sgn_mode;
    logic                w_accept;
    logic [DW-1:0]       w_mcand_mag;
    logic [DW-1:0]       w_mplier_mag;

    assign w_sgn_mode   = (SIGNED_EN != 0) && i_signed;
    assign w_accept     = o_ready && i_start;
    // -(-2^(DW-1)) wraps to 2^(DW-1), which is exactly the unsigned magnitude we want
    assign w_mcand_mag  = (w_sgn_mode && i_multiplicand[DW-1]) ? -i_multiplicand : i_multiplicand;
    assign w_mplier_mag = (w_sgn_mode && i_multiplier[DW-1])   ? -i_multiplier   : i_multiplier;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (i_start) w_next = RUN;
            RUN:        if (r_mplier == '0) w_next = FIX;
            FIX:        w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready   = (r_state == IDLE) || (r_state == DONE);
        o_done    = r_done;
        o_product = r_product;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_sign    <= 1'b0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (w_accept) begin
                r_mcand  <= {{DW{1'b0}}, w_mcand_mag};
                r_mplier <= w_mplier_mag;
                r_acc    <= '0;
                r_sign   <= w_sgn_mode && (i_multiplicand[DW-1] ^ i_multiplier[DW-1]);
            end else if ((r_state == RUN) && (r_mplier != '0)) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            // Negating a zero accumulator yields zero, so -0 never appears
            if (r_state == FIX) begin
                r_product <= r_sign ? -r_acc : r_acc;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: directed table, corner sequences, and randomized model checks
// across DW=4/8/16 signed-capable instances plus one DW=8 unsigned-only instance.
module tb_mult_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic st4, sg4, r4, d4;   logic [3:0]  a4, b4;   logic [7:0]  p4;
    logic st8, sg8, r8, d8;   logic [7:0]  a8, b8;   logic [15:0] p8;
    logic st16, sg16, r16, d16; logic [15:0] a16, b16; logic [31:0] p16;
    logic stu, sgu, ru, du;   logic [7:0]  au, bu;   logic [15:0] pu;

    mult_seq_param #(.DW(4), .SIGNED_EN(1)) dut4 (.i_clk(clk), .i_rst(rst), .i_start(st4),
        .i_signed(sg4), .i_multiplicand(a4), .i_multiplier(b4), .o_product(p4), .o_ready(r4), .o_done(d4));
    mult_seq_param #(.DW(8), .SIGNED_EN(1)) dut8 (.i_clk(clk), .i_rst(rst), .i_start(st8),
        .i_signed(sg8), .i_multiplicand(a8), .i_multiplier(b8), .o_product(p8), .o_ready(r8), .o_done(d8));
    mult_seq_param #(.DW(16), .SIGNED_EN(1)) dut16 (.i_clk(clk), .i_rst(rst), .i_start(st16),
        .i_signed(sg16), .i_multiplicand(a16), .i_multiplier(b16), .o_product(p16), .o_ready(r16), .o_done(d16));
    mult_seq_param #(.DW(8), .SIGNED_EN(0)) dutu (.i_clk(clk), .i_rst(rst), .i_start(stu),
        .i_signed(sgu), .i_multiplicand(au), .i_multiplier(bu), .o_product(pu), .o_ready(ru), .o_done(du));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          idx;
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    function automatic int dw_of(int idx);
        case (idx)
            0:       return 4;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] get_prod(int idx);
        case (idx)
            0:       return {56'b0, p4};
            1:       return {48'b0, p8};
            2:       return {32'b0, p16};
            default: return {48'b0, pu};
        endcase
    endfunction

    function automatic logic get_done(int idx);
        case (idx)
            0:       return d4;
            1:       return d8;
            2:       return d16;
            default: return du;
        endcase
    endfunction

    function automatic logic get_rdy(int idx);
        case (idx)
            0:       return r4;
            1:       return r8;
            2:       return r16;
            default: return ru;
        endcase
    endfunction

    task automatic set_in(input int idx, input logic st, input logic sg, input logic [31:0] a, input logic [31:0] b);
        case (idx)
            0:       begin st4 = st;  sg4 = sg;  a4 = a[3:0];   b4 = b[3:0];   end
            1:       begin st8 = st;  sg8 = sg;  a8 = a[7:0];   b8 = b[7:0];   end
            2:       begin st16 = st; sg16 = sg; a16 = a[15:0]; b16 = b[15:0]; end
            default: begin stu = st;  sgu = sg;  au = a[7:0];   bu = b[7:0];   end
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: true integer product of the operands as interpreted, truncated to 2*DW
    function automatic logic [63:0] ref_prod(input int dw, input bit sgn, input longint a, input longint b);
        longint sa = a;
        longint sb = b;
        if (sgn) begin
            if (a >= (longint'(1) << (dw - 1))) sa = a - (longint'(1) << dw);
            if (b >= (longint'(1) << (dw - 1))) sb = b - (longint'(1) << dw);
        end
        return (sa * sb) & ((longint'(1) << (2 * dw)) - 1);
    endfunction

    function automatic int ref_lat(input int dw, input bit sgn, input longint b);
        longint mag = b;
        int k = 0;
        if (sgn && b >= (longint'(1) << (dw - 1))) mag = (longint'(1) << dw) - b;
        for (int i = 0; i <= dw; i++) if (mag[i]) k = i + 1;
        return k + 2;
    endfunction

    task automatic wait_done(input int idx, output int lat);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (get_done(idx)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_op(input string name, input int idx, input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_p, input int exp_lat);
        int lat;
        @(negedge clk);
        set_in(idx, 1'b1, sg, a, b);
        @(posedge clk); #1;
        set_in(idx, 1'b0, sg, a, b);
        wait_done(idx, lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " product"}, get_prod(idx), exp_p);
        @(posedge clk); #1;
        check({name, " done pulse/ready/hold"}, {61'b0, get_done(idx), get_rdy(idx), 1'b0} | 64'(0),
              {61'b0, 1'b0, 1'b1, 1'b0});
        check({name, " product held"}, get_prod(idx), exp_p);
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb;
        bit rs, eff;
        int dw;

        tbl[0] = '{1, 1'b0, 32'h05, 32'h03, 64'h000F, 4};
        tbl[1] = '{1, 1'b1, 32'hFD, 32'h05, 64'hFFF1, 5};
        tbl[2] = '{1, 1'b1, 32'h80, 32'h80, 64'h4000, 10};
        tbl[3] = '{1, 1'b1, 32'h7F, 32'h80, 64'hC080, 10};
        tbl[4] = '{1, 1'b1, 32'h85, 32'h00, 64'h0000, 2};
        tbl[5] = '{1, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 10};
        tbl[6] = '{1, 1'b1, 32'hFF, 32'hFF, 64'h0001, 3};
        tbl[7] = '{3, 1'b1, 32'hFD, 32'h05, 64'h04F1, 5};
        tbl[8] = '{0, 1'b1, 32'h8, 32'h8, 64'h40, 6};
        tbl[9] = '{2, 1'b1, 32'h8000, 32'h0000, 64'h0, 2};

        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_in(i, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(r8), 64'd1);
        check("reset done", 64'(d8), 64'd0);
        check("reset product", 64'(p8), 64'd0);

        // Start asserted on a reset edge must be dropped
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, 32'h05, 32'h03);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        set_in(1, 1'b0, 1'b0, 32'h05, 32'h03);
        @(posedge clk); #1;
        check("start during reset ignored", {62'b0, r8, d8}, {62'b0, 1'b1, 1'b0});

        for (int i = 0; i < 10; i++)
            do_op($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat);

        // Start held through RUN is ignored, then accepted back-to-back in DONE
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, 32'h07, 32'h07);
        @(posedge clk); #1;
        set_in(1, 1'b1, 1'b0, 32'h03, 32'h02);
        wait_done(1, lat);
        check("b2b first latency", 64'(lat), 64'd5);
        check("b2b first product", 64'(p8), 64'h0031);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 32'h03, 32'h02);
        check("b2b accepted in DONE", {62'b0, r8, d8}, {62'b0, 1'b0, 1'b0});
        check("b2b product held until FIX", 64'(p8), 64'h0031);
        wait_done(1, lat);
        check("b2b second latency", 64'(lat), 64'd4);
        check("b2b second product", 64'(p8), 64'h0006);

        // Reset in the middle of RUN abandons the operation
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, 32'hFF, 32'hFF);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 32'hFF, 32'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrun reset ready/done", {62'b0, r8, d8}, {62'b0, 1'b1, 1'b0});
        check("midrun reset product", 64'(p8), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op("after reset 9x9", 1, 1'b0, 32'h09, 32'h09, 64'h0051, 6);

        for (int idx = 0; idx < 4; idx++) begin
            dw = dw_of(idx);
            for (int n = 0; n < 25; n++) begin
                ra = $urandom & ((32'd1 << dw) - 1);
                case ($urandom_range(0, 7))
                    0:       rb = 32'd0;
                    1:       rb = 32'd1 << (dw - 1);
                    default: rb = $urandom & ((32'd1 << dw) - 1);
                endcase
                rs  = 1'($urandom_range(0, 1));
                eff = rs && (idx != 3);
                do_op($sformatf("rnd dw%0d i%0d n%0d s%0d a=%0h b=%0h", dw, idx, n, rs, ra, rb), idx, rs,
                      ra, rb, ref_prod(dw, eff, longint'(ra), longint'(rb)),
                      ref_lat(dw, eff, longint'(rb)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_param.md
MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 Parameter DW, default 8: operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED_EN, default 1: when 0, i_signed is ignored and all operations are unsigned.
REQ-003 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1: reset, synchronous, active-low.
REQ-005 Port i_start, input, 1: request a new multiplication; sampled only when o_ready=1.
REQ-006 Port i_signed, input, 1: 1 = two's-complement operands, 0 = unsigned; sampled with i_start.
REQ-007 Port i_multiplicand, input, DW: multiplicand operand; sampled with i_start.
REQ-008 Port i_multiplier, input, DW: multiplier operand; sampled with i_start.
REQ-009 Port o_product, output, 2*DW: result, held stable from o_done until the next accepted start.
REQ-010 Port o_ready, output, 1: high in IDLE and DONE; a new start is accepted.
REQ-011 Port o_done, output, 1: one-cycle pulse on the first cycle in DONE.

Function
REQ-012 The block SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-013 On an edge where o_ready=1 and i_start=1, the block SHALL latch operand magnitudes, the result sign (XOR of operand MSBs if signed mode, else 0), clear the 2*DW accumulator, and go to RUN.
REQ-014 Magnitude conversion: if signed mode and operand MSB=1, the magnitude SHALL be the two's complement, held in a DW-bit unsigned register; -2^(DW-1) SHALL give magnitude 2^(DW-1).
REQ-015 In RUN with multiplier register nonzero: if multiplier LSB=1, accumulator += multiplicand register (2*DW wide); multiplicand shifts left 1; multiplier shifts right 1.
REQ-016 In RUN with multiplier register zero, the block SHALL make no add and go to FIX (early termination).
REQ-017 In FIX, the block SHALL load o_product with the accumulator, negated (two's complement, 2*DW bits) if the sign is 1, and go to DONE.
REQ-018 In DONE, o_done SHALL be high for exactly one cycle. The state SHALL remain DONE until an accepted start.
REQ-019 Latency: with k = index of the highest set bit of the multiplier magnitude plus 1 (k=0 for zero), o_done SHALL rise k+2 clocks after the start-sampling edge; the maximum is DW+2.
REQ-020 i_start while in RUN or FIX SHALL be ignored, with no effect on operands or timing.
REQ-021 i_start in DONE SHALL begin a new operation on the same edge. o_product SHALL hold its old value until FIX.
REQ-022 A zero result SHALL never be negated to a nonzero pattern; -0 yields 0.
REQ-023 Arithmetic SHALL never overflow 2*DW bits for any legal operands in either mode.

Reset
REQ-024 When i_rst=0 at an edge, the block SHALL enter IDLE from any state, including mid-RUN or FIX, and abandon the operation.
REQ-025 Reset values: o_product=0, o_done=0, o_ready=1, accumulator, operand and sign registers = 0.
REQ-026 i_start on a reset edge SHALL be ignored; the first acceptable start is on the edge after i_rst returns to 1.

Verification
REQ-027 DW=8, unsigned: 5 x 3 -> o_product=0x000F; o_done 4 clocks after the start edge (k=2).
REQ-028 DW=8, signed: -3 (0xFD) x 5 -> 0xFFF1; -128 x -128 -> 0x4000; 127 x -128 -> 0xC080 with o_done at 10 clocks (k=8).
REQ-029 Multiplier 0 with any multiplicand -> o_product=0, o_done 2 clocks after start, no negative zero in signed mode.
REQ-030 Start 7x7, then hold i_start=1 with new operands during RUN -> second request ignored; result 0x0031; the back-to-back start in DONE is accepted and produces the new result.
REQ-031 Assert i_rst=0 mid-RUN -> next cycle shows o_ready=1, o_done=0, o_product=0; the next operation completes correctly.
REQ-032 Random signed and unsigned operands with DW=4, 8 and 16 -> o_product matches a reference model and latency matches REQ-019.
